// File: rtl/axi_lite_2_apb_nslv.sv
// AXI4-Lite slave to APB master bridge driving N address-decoded APB slaves on one shared bus.
// One transfer in flight; reads and writes alternate when both are pending.
module axi_lite_2_apb_nslv #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int N_SLAVES       = 4,
    parameter int SLV_ADDR_BITS  = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                               S_AXI_ACLK,
    input  logic                               S_AXI_ARESETN,
    input  logic [AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    output logic [1:0]                         S_AXI_BRESP,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    output logic [AXI_ADDR_WIDTH-1:0]          PADDR,
    output logic [2:0]                         PPROT,
    output logic                               PWRITE,
    output logic [AXI_DATA_WIDTH-1:0]          PWDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]        PSTRB,
    output logic [N_SLAVES-1:0]                PSEL,
    output logic                               PENABLE,
    input  logic [N_SLAVES-1:0]                PREADY,
    input  logic [N_SLAVES*AXI_DATA_WIDTH-1:0] PRDATA,
    input  logic [N_SLAVES-1:0]                PSLVERR
);

    localparam int IDX_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                    state;
    logic                      last_wr;
    logic                      is_wr;
    logic [IDX_W-1:0]          idx_q;
    logic [TMO_W-1:0]          tmo_cnt;

    logic                      wr_elig;
    logic                      rd_elig;
    logic                      pick_wr;
    logic [AXI_ADDR_WIDTH-1:0] gnt_addr;
    logic [IDX_W-1:0]          gnt_idx;
    logic                      gnt_ok;
    logic                      sel_ready;
    logic                      sel_err;
    logic [AXI_DATA_WIDTH-1:0] sel_rdata;
    logic                      tmo_hit;
    logic [1:0]                acc_resp;

    function automatic logic [IDX_W-1:0] slv_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
        if (N_SLAVES == 1)
            return '0;
        else
            return addr[SLV_ADDR_BITS +: IDX_W];
    endfunction

    always_comb begin
        wr_elig   = S_AXI_AWVALID && S_AXI_WVALID;
        rd_elig   = S_AXI_ARVALID;
        // On a tie the type that was not served last wins.
        pick_wr   = wr_elig && (!rd_elig || !last_wr);
        gnt_addr  = is_wr ? S_AXI_AWADDR : S_AXI_ARADDR;
        gnt_idx   = slv_idx(gnt_addr);
        gnt_ok    = (N_SLAVES == 1) || (32'(gnt_idx) < N_SLAVES);
        sel_ready = PREADY[idx_q];
        sel_err   = PSLVERR[idx_q];
        sel_rdata = PRDATA[idx_q*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_W'(TMO_LAST));
        acc_resp  = (!sel_ready || sel_err) ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state         <= IDLE;
            last_wr       <= 1'b0;
            is_wr         <= 1'b0;
            idx_q         <= '0;
            tmo_cnt       <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RRESP   <= 2'b00;
            S_AXI_RDATA   <= '0;
            PADDR         <= '0;
            PPROT         <= 3'b000;
            PWRITE        <= 1'b0;
            PWDATA        <= '0;
            PSTRB         <= '0;
            PSEL          <= '0;
            PENABLE       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Ready high means the handshake completes on this edge.
                    if (S_AXI_AWREADY || S_AXI_ARREADY) begin
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b0;
                        S_AXI_ARREADY <= 1'b0;
                        idx_q         <= gnt_idx;
                        tmo_cnt       <= '0;
                        if (gnt_ok) begin
                            PSEL   <= N_SLAVES'(1) << gnt_idx;
                            PADDR  <= gnt_addr;
                            PPROT  <= is_wr ? S_AXI_AWPROT : S_AXI_ARPROT;
                            PWRITE <= is_wr;
                            PWDATA <= is_wr ? S_AXI_WDATA : '0;
                            PSTRB  <= is_wr ? S_AXI_WSTRB : '0;
                            state  <= SETUP;
                        end else begin
                            if (is_wr) begin
                                S_AXI_BVALID <= 1'b1;
                                S_AXI_BRESP  <= RESP_DECERR;
                            end else begin
                                S_AXI_RVALID <= 1'b1;
                                S_AXI_RRESP  <= RESP_DECERR;
                                S_AXI_RDATA  <= '0;
                            end
                            state <= RESP;
                        end
                    end else if (wr_elig || rd_elig) begin
                        is_wr         <= pick_wr;
                        last_wr       <= pick_wr;
                        S_AXI_AWREADY <= pick_wr;
                        S_AXI_WREADY  <= pick_wr;
                        S_AXI_ARREADY <= !pick_wr;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (sel_ready || tmo_hit) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        state   <= RESP;
                        if (is_wr) begin
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BRESP  <= acc_resp;
                        end else begin
                            S_AXI_RVALID <= 1'b1;
                            S_AXI_RRESP  <= acc_resp;
                            S_AXI_RDATA  <= sel_ready ? sel_rdata : '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                RESP: begin
                    if ((S_AXI_BVALID && S_AXI_BREADY) || (S_AXI_RVALID && S_AXI_RREADY)) begin
                        S_AXI_BVALID <= 1'b0;
                        S_AXI_RVALID <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_2_apb_nslv.sv
// Bench for axi_lite_2_apb_nslv with three APB slaves: directed AXI traffic, queue-based response checking
// and cycle-level checks of the APB phases.
module tb_axi_lite_2_apb_nslv;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int NS = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   awaddr, araddr;
    logic [2:0]      awprot, arprot;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rvalid, rready;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0]      bresp, rresp;
    logic [AW-1:0]   paddr;
    logic [2:0]      pprot;
    logic            pwrite, penable;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
    logic [NS-1:0]   psel, pready, pslverr;
    logic [NS*DW-1:0] prdata;

    always #5 clk = ~clk;

    axi_lite_2_apb_nslv #(
        .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .N_SLAVES(NS),
        .SLV_ADDR_BITS(12), .TIMEOUT_CYCLES(16)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .PADDR(paddr), .PPROT(pprot), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
        .PSEL(psel), .PENABLE(penable), .PREADY(pready), .PRDATA(prdata), .PSLVERR(pslverr)
    );

    // APB slave models; unselected slaves drive PREADY/PSLVERR high so the bridge must ignore them.
    logic [7:0]  wait_cfg [NS];
    logic        hang     [NS];
    logic        err_cfg  [NS];
    logic [31:0] rd_cfg   [NS];
    logic [7:0]  acc_cnt  [NS];

    always @(posedge clk)
        for (int i = 0; i < NS; i++)
            acc_cnt[i] <= (psel[i] && penable && !pready[i]) ? acc_cnt[i] + 8'd1 : 8'd0;

    always_comb begin
        pready  = '0;
        pslverr = '0;
        prdata  = '0;
        for (int i = 0; i < NS; i++) begin
            prdata[i*DW +: DW] = rd_cfg[i];
            pslverr[i] = psel[i] ? err_cfg[i] : 1'b1;
            pready[i]  = psel[i] ? (penable && !hang[i] && (acc_cnt[i] >= wait_cfg[i])) : 1'b1;
        end
    end

    typedef struct {
        logic        wr;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic order[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endfunction

    function automatic void push_exp(input logic wr, input logic [1:0] resp, input logic [31:0] data);
        exp_t e;
        e.wr = wr; e.resp = resp; e.data = data;
        sb.push_back(e);
    endfunction

    // Response monitor: compares every completed B/R handshake against the head of the queue.
    always @(negedge clk) begin
        if (bvalid && bready) begin
            if (sb.size() == 0) begin
                chk("b_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("b_kind", 1, {63'd0, mon_e.wr});
                chk("bresp", {62'd0, bresp}, {62'd0, mon_e.resp});
            end
        end
        if (rvalid && rready) begin
            if (sb.size() == 0) begin
                chk("r_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("r_kind", 0, {63'd0, mon_e.wr});
                chk("rresp", {62'd0, rresp}, {62'd0, mon_e.resp});
                chk("rdata", {32'd0, rdata}, {32'd0, mon_e.data});
            end
        end
    end

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        int n = 0;
        awaddr = a; awprot = 3'b010; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        while (!(awready && wready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("aw_grant_timeout", 0, 1);
        @(posedge clk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        order.push_back(1'b1);
    endtask

    task automatic axi_read(input logic [AW-1:0] a);
        int n = 0;
        araddr = a; arprot = 3'b001; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ar_grant_timeout", 0, 1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        order.push_back(1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bvalid || rvalid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic stable;
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; arvalid = 0; wdata = '0; wstrb = '0;
        bready = 1'b1; rready = 1'b1;
        for (int i = 0; i < NS; i++) begin
            wait_cfg[i] = 8'd0; hang[i] = 1'b0; err_cfg[i] = 1'b0;
        end
        rd_cfg[0] = 32'h0000_00A0;
        rd_cfg[1] = 32'h0000_B111;
        rd_cfg[2] = 32'h1234_5678;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata, psel, penable, paddr, pwrite}, 0);
        chk("reset_apb", {pwdata, pstrb, pprot}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Simultaneous write and read, twice: write wins each time, read follows.
        for (int r = 0; r < 2; r++) begin
            order.delete();
            push_exp(1'b1, 2'b00, 32'd0);
            push_exp(1'b0, 2'b00, 32'h0000_B111);
            fork
                axi_write(16'h0010, 32'hCAFE_0000 + r, 4'hF);
                axi_read(16'h1000);
            join
            chk("arb_first_is_write", {63'd0, order[0]}, 1);
            chk("arb_second_is_read", {63'd0, order[1]}, 0);
            drain();
        end

        // Zero-wait write to slave 1: SETUP, ACCESS, BVALID on consecutive cycles.
        push_exp(1'b1, 2'b00, 32'd0);
        axi_write(16'h1004, 32'hA5A5_0001, 4'hF);
        @(negedge clk);
        chk("wr_setup_psel", {61'd0, psel}, 3'b010);
        chk("wr_setup_penable", {63'd0, penable}, 0);
        chk("wr_setup_paddr", {48'd0, paddr}, 16'h1004);
        chk("wr_setup_pwrite", {63'd0, pwrite}, 1);
        chk("wr_setup_pwdata", {32'd0, pwdata}, 32'hA5A5_0001);
        chk("wr_setup_pstrb", {60'd0, pstrb}, 4'hF);
        chk("wr_setup_pprot", {61'd0, pprot}, 3'b010);
        @(negedge clk);
        chk("wr_access_penable", {63'd0, penable}, 1);
        chk("wr_access_psel", {61'd0, psel}, 3'b010);
        @(negedge clk);
        chk("wr_bvalid_n3", {63'd0, bvalid}, 1);
        drain();

        // Read from slave 2 with three wait states.
        wait_cfg[2] = 8'd3;
        push_exp(1'b0, 2'b00, 32'h1234_5678);
        axi_read(16'h2008);
        @(negedge clk);
        chk("rd_setup_psel", {61'd0, psel}, 3'b100);
        chk("rd_setup_write_fields", {31'd0, pwrite, pwdata, pstrb}, 0);
        chk("rd_setup_pprot", {61'd0, pprot}, 3'b001);
        n = 0; stable = 1'b1;
        @(negedge clk);
        while (penable && n < 50) begin
            n++;
            if (psel !== 3'b100 || paddr !== 16'h2008) stable = 1'b0;
            @(negedge clk);
        end
        chk("rd_access_cycles", n, 4);
        chk("rd_access_stable", {63'd0, stable}, 1);
        wait_cfg[2] = 8'd0;
        drain();

        // Unmapped window: DECERR one cycle after the grant, no APB select.
        push_exp(1'b0, 2'b11, 32'd0);
        axi_read(16'h3000);
        @(negedge clk);
        chk("decerr_no_psel", {61'd0, psel}, 0);
        chk("decerr_rvalid_n1", {63'd0, rvalid}, 1);
        drain();

        // Slave error on write.
        err_cfg[0] = 1'b1;
        push_exp(1'b1, 2'b10, 32'd0);
        axi_write(16'h0020, 32'h0000_0055, 4'h3);
        drain();
        err_cfg[0] = 1'b0;

        // Slave never ready: abort after 16 ACCESS cycles.
        hang[0] = 1'b1;
        push_exp(1'b0, 2'b10, 32'd0);
        axi_read(16'h0040);
        @(negedge clk);
        n = 0;
        @(negedge clk);
        while (penable && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_access_cycles", n, 16);
        chk("timeout_psel_dropped", {61'd0, psel}, 0);
        chk("timeout_rvalid", {63'd0, rvalid}, 1);
        hang[0] = 1'b0;
        drain();

        // BREADY held low: BVALID and BRESP must hold.
        bready = 1'b0;
        push_exp(1'b1, 2'b00, 32'd0);
        axi_write(16'h1008, 32'h0BAD_F00D, 4'hC);
        n = 0;
        while (!bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bhold_seen", {63'd0, bvalid}, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bhold_bvalid", {63'd0, bvalid}, 1);
            chk("bhold_bresp", {62'd0, bresp}, 0);
        end
        @(posedge clk);
        #1 bready = 1'b1;
        drain();

        // Reset in the middle of ACCESS: no response, next write completes.
        hang[2] = 1'b1;
        axi_read(16'h2000);
        n = 0;
        while (!penable && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reset_in_access", {63'd0, penable}, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset_ctrl", {awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata, psel, penable, paddr, pwrite}, 0);
        chk("mid_reset_apb", {pwdata, pstrb, pprot}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hang[2] = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_reset_no_resp", {62'd0, bvalid, rvalid}, 0);
        push_exp(1'b1, 2'b00, 32'd0);
        axi_write(16'h2010, 32'h7777_0001, 4'hF);
        drain();

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
